wb_axis_bridge: RTL and testbench

//  Buffered bridge between the Wishbone stream window and the FIR AXI-Stream ports.
//  WB writes to X push into an input FIFO that drives ss_*. FIR output on sm_* fills
//  an output FIFO that WB pops through Y, so the CPU never stalls the FIR pipeline directly.
//  ss_tlast comes from a programmable sample counter, not from data values.

---
 rtl/wb_axis_bridge.sv | 225 ++++++++++++++++++++++
 tb/tb_wb_axis_bridge.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_axis_bridge.sv
// Wishbone stream window <-> FIR AXI-Stream bridge with an input and an output FIFO.
// WB ack is registered (1 cycle min); X writes stall on full, Y reads stall on empty.

// Generic FIFO: a same-cycle pop frees a slot, so a full FIFO can still take a push.
module wb_axis_bridge_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push_vld,
  input  logic [W-1:0]     push_dat,
  input  logic             pop_rdy,
  output logic [W-1:0]     head_dat,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_en;
  logic          pop_en;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop_en   = pop_rdy & ~empty;
  assign push_en  = push_vld & (~full | pop_en);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end
endmodule

module wb_axis_bridge #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [4:0]        wbs_adr_i,
  input  logic [DATA_W-1:0] wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [DATA_W-1:0] wbs_dat_o,
  output logic              ss_tvalid,
  input  logic              ss_tready,
  output logic [DATA_W-1:0] ss_tdata,
  output logic              ss_tlast,
  input  logic              sm_tvalid,
  output logic              sm_tready,
  input  logic [DATA_W-1:0] sm_tdata,
  input  logic              sm_tlast,
  output logic              irq
);
  localparam logic [4:0] ADR_X      = 5'h00;
  localparam logic [4:0] ADR_Y      = 5'h04;
  localparam logic [4:0] ADR_STATUS = 5'h08;
  localparam logic [4:0] ADR_CTRL   = 5'h0C;
  localparam logic [4:0] ADR_LEN    = 5'h10;

  typedef struct packed {
    logic [10:0] rsv_hi;
    logic [4:0]  out_count;
    logic [2:0]  rsv_mid;
    logic [4:0]  in_count;
    logic [2:0]  rsv_lo;
    logic        last_seen;
    logic        out_empty;
    logic        out_full;
    logic        in_empty;
    logic        in_full;
  } status_t;

  logic              wb_req;
  logic              wb_ok;
  logic              wb_go;
  logic              ctrl_wr;
  logic              len_wr;
  logic              clr;
  logic              irq_en;
  logic              last_seen;
  logic [DATA_W-1:0] len;
  logic [DATA_W-1:0] last_idx;
  logic [DATA_W-1:0] frame_cnt;
  logic [DATA_W-1:0] rd_dat;
  status_t           status;

  logic              in_push_vld;
  logic              in_pop;
  logic              in_push_ok;
  logic [DATA_W-1:0] in_head_dat;
  logic              in_full;
  logic              in_empty;
  logic [CNT_W-1:0]  in_count;

  logic              out_push_vld;
  logic              out_pop_rdy;
  logic [DATA_W-1:0] out_head_dat;
  logic              out_full;
  logic              out_empty;
  logic [CNT_W-1:0]  out_count;

  // the registered ack blocks a new request in the cycle after an ack
  assign wb_req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;

  assign in_pop     = ss_tvalid & ss_tready;
  assign in_push_ok = ~in_full | in_pop;

  always_comb begin
    wb_ok = 1'b1;
    if (wbs_we_i && wbs_adr_i == ADR_X)       wb_ok = in_push_ok;
    else if (!wbs_we_i && wbs_adr_i == ADR_Y) wb_ok = ~out_empty;
  end

  assign wb_go        = wb_req & wb_ok;
  assign in_push_vld  = wb_req & wbs_we_i & (wbs_adr_i == ADR_X);
  assign out_pop_rdy  = wb_req & ~wbs_we_i & (wbs_adr_i == ADR_Y);
  assign ctrl_wr      = wb_go & wbs_we_i & (wbs_adr_i == ADR_CTRL);
  assign len_wr       = wb_go & wbs_we_i & (wbs_adr_i == ADR_LEN);
  assign clr          = ctrl_wr & wbs_dat_i[0];

  assign sm_tready    = ~rst & ~out_full;
  assign out_push_vld = sm_tvalid & sm_tready;

  // LEN of zero behaves as a one-sample frame
  assign last_idx  = (len == '0) ? '0 : len - DATA_W'(1);
  assign ss_tvalid = ~in_empty;
  assign ss_tdata  = in_head_dat;
  assign ss_tlast  = ss_tvalid & (frame_cnt == last_idx);
  assign irq       = last_seen & irq_en;

  always_comb begin
    status           = '0;
    status.in_full   = in_full;
    status.in_empty  = in_empty;
    status.out_full  = out_full;
    status.out_empty = out_empty;
    status.last_seen = last_seen;
    status.in_count  = 5'(in_count);
    status.out_count = 5'(out_count);
  end

  always_comb begin
    rd_dat = '0;
    case (wbs_adr_i)
      ADR_Y:      rd_dat = out_head_dat;
      ADR_STATUS: rd_dat = DATA_W'(status);
      ADR_CTRL:   rd_dat[1] = irq_en;
      ADR_LEN:    rd_dat = len;
      default:    rd_dat = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq_en    <= 1'b0;
      len       <= DATA_W'(64);
      frame_cnt <= '0;
      last_seen <= 1'b0;
    end else begin
      wbs_ack_o <= wb_go;
      wbs_dat_o <= (wb_go & ~wbs_we_i) ? rd_dat : '0;
      if (ctrl_wr) irq_en <= wbs_dat_i[1];
      if (len_wr)  len    <= wbs_dat_i;
      // >= rather than == so a LEN shrunk below the current position still wraps
      if (clr)         frame_cnt <= '0;
      else if (in_pop) frame_cnt <= (frame_cnt >= last_idx) ? '0 : frame_cnt + DATA_W'(1);
      if (clr)                          last_seen <= 1'b0;
      else if (out_push_vld & sm_tlast) last_seen <= 1'b1;
    end
  end

  wb_axis_bridge_fifo #(.W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_in_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .push_vld (in_push_vld),
    .push_dat (wbs_dat_i),
    .pop_rdy  (ss_tready),
    .head_dat (in_head_dat),
    .full     (in_full),
    .empty    (in_empty),
    .count    (in_count)
  );

  wb_axis_bridge_fifo #(.W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_out_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .push_vld (out_push_vld),
    .push_dat (sm_tdata),
    .pop_rdy  (out_pop_rdy),
    .head_dat (out_head_dat),
    .full     (out_full),
    .empty    (out_empty),
    .count    (out_count)
  );
endmodule

// File: tb/tb_wb_axis_bridge.sv
// Directed bench for wb_axis_bridge: WB window accesses, FIFO stalls, framing and clear.
module tb_wb_axis_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [4:0]  wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        ss_tvalid;
  logic        ss_tready;
  logic [31:0] ss_tdata;
  logic        ss_tlast;
  logic        sm_tvalid;
  logic        sm_tready;
  logic [31:0] sm_tdata;
  logic        sm_tlast;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_axis_bridge #(.DATA_W(32), .DEPTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .ss_tvalid (ss_tvalid),
    .ss_tready (ss_tready),
    .ss_tdata  (ss_tdata),
    .ss_tlast  (ss_tlast),
    .sm_tvalid (sm_tvalid),
    .sm_tready (sm_tready),
    .sm_tdata  (sm_tdata),
    .sm_tlast  (sm_tlast),
    .irq       (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                         output logic acked, output logic [31:0] rdat);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    acked = 1'b0;
    rdat  = '0;
    for (int i = 0; i < 10 && !acked; i++) begin
      tick(1);
      if (wbs_ack_o) begin
        acked = 1'b1;
        rdat  = wbs_dat_o;
      end
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic wb_wr(input string tag, input logic [4:0] adr, input logic [31:0] dat);
    logic        a;
    logic [31:0] d;
    wb_xfer(1'b1, adr, dat, a, d);
    check({tag, "_ack"}, {31'b0, a}, 32'd1);
  endtask

  task automatic wb_rd(input string tag, input logic [4:0] adr, input logic [31:0] exp);
    logic        a;
    logic [31:0] d;
    wb_xfer(1'b0, adr, 32'h0, a, d);
    check({tag, "_ack"}, {31'b0, a}, 32'd1);
    check(tag, d, exp);
  endtask

  task automatic sm_push(input logic [31:0] dat, input logic last);
    sm_tvalid = 1'b1;
    sm_tdata  = dat;
    sm_tlast  = last;
    tick(1);
    sm_tvalid = 1'b0;
    sm_tlast  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        seen;
    logic        acked;
    logic [31:0] rdat;

    rst = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_adr_i = '0;   wbs_dat_i = '0;
    ss_tready = 1'b0; sm_tvalid = 1'b0; sm_tdata = '0; sm_tlast = 1'b0;
    tick(3);
    check("rst_ack",       {31'b0, wbs_ack_o}, 32'd0);
    check("rst_dat_o",     wbs_dat_o,          32'd0);
    check("rst_ss_tvalid", {31'b0, ss_tvalid}, 32'd0);
    check("rst_ss_tlast",  {31'b0, ss_tlast},  32'd0);
    check("rst_sm_tready", {31'b0, sm_tready}, 32'd0);
    check("rst_irq",       {31'b0, irq},       32'd0);
    rst = 1'b0;
    tick(1);

    // T1: reset release
    check("t1_ss_tvalid", {31'b0, ss_tvalid}, 32'd0);
    check("t1_sm_tready", {31'b0, sm_tready}, 32'd1);
    check("t1_irq",       {31'b0, irq},       32'd0);
    wb_rd("t1_status", 5'h08, 32'h0000_000A);
    wb_rd("x_read_zero", 5'h00, 32'h0);
    wb_rd("unmapped_zero", 5'h14, 32'h0);

    // T2: fill in-FIFO, 9th write stalls until one ss pop
    for (int i = 0; i < 8; i++) wb_wr("t2_x_wr", 5'h00, 32'h100 + i);
    check("t2_ss_tvalid", {31'b0, ss_tvalid}, 32'd1);
    check("t2_head",      ss_tdata,           32'h100);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 5'h00; wbs_dat_i = 32'h200;
    seen = 1'b0;
    repeat (3) begin
      tick(1);
      seen |= wbs_ack_o;
    end
    check("t2_x9_stall", {31'b0, seen}, 32'd0);
    ss_tready = 1'b1;
    tick(1);
    ss_tready = 1'b0;
    check("t2_x9_ack", {31'b0, wbs_ack_o}, 32'd1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    check("t2_head_after_pop", ss_tdata, 32'h101);
    wb_rd("t2_status", 5'h08, 32'h0000_0809);

    // T5: full FIFO, pop and WB push in the same cycle
    tick(1);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 5'h00; wbs_dat_i = 32'h300;
    ss_tready = 1'b1;
    tick(1);
    ss_tready = 1'b0;
    check("t5_ack", {31'b0, wbs_ack_o}, 32'd1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    check("t5_head", ss_tdata, 32'h102);
    wb_rd("t5_status", 5'h08, 32'h0000_0809);
    wb_wr("flush", 5'h0C, 32'h1);
    wb_rd("flush_status", 5'h08, 32'h0000_000A);

    // T3: LEN=3 framing over six samples
    wb_wr("t3_len", 5'h10, 32'd3);
    for (int i = 1; i <= 6; i++) wb_wr("t3_x_wr", 5'h00, i);
    ss_tready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      check("t3_tdata", ss_tdata, i);
      check("t3_tlast", {31'b0, ss_tlast}, (i == 3 || i == 6) ? 32'd1 : 32'd0);
      tick(1);
    end
    ss_tready = 1'b0;
    check("t3_drained", {31'b0, ss_tvalid}, 32'd0);

    // T4: FIR results through Y, last_seen and irq
    sm_push(32'd10, 1'b0);
    sm_push(32'd20, 1'b0);
    sm_push(32'd30, 1'b1);
    check("t4_irq_masked", {31'b0, irq}, 32'd0);
    wb_rd("t4_status", 5'h08, 32'h0003_0012);
    wb_wr("t4_irq_en", 5'h0C, 32'h2);
    check("t4_irq", {31'b0, irq}, 32'd1);
    wb_rd("t4_y0", 5'h04, 32'd10);
    wb_rd("t4_y1", 5'h04, 32'd20);
    wb_rd("t4_y2", 5'h04, 32'd30);
    wb_rd("t4_ctrl", 5'h0C, 32'h2);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = 5'h04;
    seen = 1'b0;
    repeat (3) begin
      tick(1);
      seen |= wbs_ack_o;
    end
    check("t4_y3_stall", {31'b0, seen}, 32'd0);
    sm_push(32'd40, 1'b0);
    acked = 1'b0;
    rdat  = '0;
    for (int i = 0; i < 5 && !acked; i++) begin
      tick(1);
      if (wbs_ack_o) begin
        acked = 1'b1;
        rdat  = wbs_dat_o;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    check("t4_y3_ack", {31'b0, acked}, 32'd1);
    check("t4_y3", rdat, 32'd40);

    // T6: clear with both FIFOs half full
    for (int i = 0; i < 4; i++) wb_wr("t6_x_wr", 5'h00, 32'h500 + i);
    for (int i = 0; i < 4; i++) sm_push(32'h600 + i, 1'b0);
    wb_rd("t6_status_pre", 5'h08, 32'h0004_0410);
    check("t6_irq_pre", {31'b0, irq}, 32'd1);
    wb_wr("t6_clear", 5'h0C, 32'h3);
    check("t6_ss_tvalid", {31'b0, ss_tvalid}, 32'd0);
    check("t6_irq",       {31'b0, irq},       32'd0);
    wb_rd("t6_status", 5'h08, 32'h0000_000A);
    wb_rd("t6_ctrl", 5'h0C, 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
